// File: rtl/imm_gen_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_pkg
// Purpose  : Shared types and constants for the decode-stage immediate
//            generator: the 3-bit immediate format encoding, the RV opcode
//            constants and an opcode-to-format helper used when the
//            IMM_OPCODE_DECODE_EN build option is defined.
// Revision : 1.0 - initial release
// ============================================================================
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_J   = 3'b011,
        FMT_U   = 3'b100,
        FMT_Z   = 3'b101,
        FMT_SH  = 3'b110,
        FMT_ILL = 3'b111
    } fmt_e;

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // Opcode/funct3 to immediate format. Shift-immediates (funct3 001/101 of
    // OP-IMM) carry a shamt rather than a signed immediate; CSR*I forms
    // (funct3[2] set) carry a 5-bit zero-extended uimm.
    function automatic fmt_e decode_fmt(input logic [6:0] opcode,
                                        input logic [2:0] funct3);
        fmt_e f;
        case (opcode)
            c_OP_IMM:    f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
            c_OP_LOAD,
            c_OP_JALR:   f = FMT_I;
            c_OP_STORE:  f = FMT_S;
            c_OP_BRANCH: f = FMT_B;
            c_OP_JAL:    f = FMT_J;
            c_OP_LUI,
            c_OP_AUIPC:  f = FMT_U;
            c_OP_SYSTEM: f = funct3[2] ? FMT_Z : FMT_I;
            default:     f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_imm_extract.sv
`default_nettype none
// ============================================================================
// Module   : imm_extract
// Purpose  : Purely combinational immediate extraction. Given the upper
//            instruction bits and a format code, produce the XLEN-wide
//            extended immediate and an illegal flag (imm forced to 0 when
//            illegal).
// Ports    : i_instr   [31:7]   instruction bits (opcode field not needed)
//            i_fmt     fmt_e    format to apply
//            o_imm     [XLEN]   extended immediate
//            o_illegal          format illegal or field invalid
// Revision : 1.0 - initial release
// ============================================================================
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  fmt_e            i_fmt,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    // Every format fits in 32 bits, so build a 32-bit value first and widen
    // it once, either sign- or zero-extending. For XLEN=64 this also gives
    // the U format its bit-31 sign extension.
    logic [31:0] w_imm32;
    logic        w_sext;

    always_comb begin
        w_imm32   = '0;
        w_sext    = 1'b1;
        o_illegal = 1'b0;
        case (i_fmt)
            FMT_I:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:  w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_J:  w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21], 1'b0};
            FMT_U:  w_imm32 = {i_instr[31:12], 12'b0};
            FMT_Z: begin
                w_imm32 = {27'b0, i_instr[19:15]};
                w_sext  = 1'b0;
            end
            FMT_SH: begin
                w_sext = 1'b0;
                // A 6-bit shamt is only meaningful on a 64-bit datapath.
                if (XLEN == 32 && i_instr[25]) begin
                    o_illegal = 1'b1;
                end else begin
                    w_imm32 = {26'b0, i_instr[25:20]};
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered decode-stage immediate generator with a two-entry
//            skid buffer (output + skid register) on a valid/ready stream.
//            Produces extended immediate, PC-relative target, applied format
//            and illegal flag one cycle after acceptance, plus a saturating
//            count of accepted illegal beats.
// Build    : IMM_OPCODE_DECODE_EN - when defined the format is decoded from
//            in_instr[6:0] (and funct3) and in_imm_src is ignored.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready, in_instr[31:0], in_imm_src[2:0], in_pc[XLEN]
//            out_valid/out_ready, out_imm, out_target, out_pc, out_fmt,
//            out_illegal, illegal_cnt[CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Format selection
    // ------------------------------------------------------------------
    fmt_e w_fmt;
    logic w_unused;

`ifdef IMM_OPCODE_DECODE_EN
    assign w_fmt    = decode_fmt(in_instr[6:0], in_instr[14:12]);
    assign w_unused = &{1'b0, in_imm_src, 1'b0};
`else
    assign w_fmt    = fmt_e'(in_imm_src);
    assign w_unused = &{1'b0, in_instr[6:0], 1'b0};
`endif

    // ------------------------------------------------------------------
    // Input-side computation (imm, target) ahead of the registers
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;

    imm_extract #(
        .XLEN (XLEN)
    ) u_imm_extract (
        .i_instr   (in_instr[31:7]),
        .i_fmt     (w_fmt),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    // Illegal beats have imm forced to 0, so target collapses to pc.
    assign w_target = in_pc + w_imm;

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [XLEN-1:0]  r_out_target;
    logic [XLEN-1:0]  r_out_pc;
    logic [2:0]       r_out_fmt;
    logic             r_out_illegal;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [XLEN-1:0]  r_skid_target;
    logic [XLEN-1:0]  r_skid_pc;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_illegal;

    logic [CNT_W-1:0] r_illegal_cnt;

    logic w_accept;
    logic w_out_free;
    logic w_cnt_inc;

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready   = !r_skid_valid;
    assign w_accept   = in_valid && !r_skid_valid;
    // Output register can take a new value: empty or draining this edge.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_cnt_inc  = w_accept && w_illegal && (r_illegal_cnt != {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_imm      <= '0;
            r_out_target   <= '0;
            r_out_pc       <= '0;
            r_out_fmt      <= '0;
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_target  <= '0;
            r_skid_pc      <= '0;
            r_skid_fmt     <= '0;
            r_skid_illegal <= 1'b0;
            r_illegal_cnt  <= '0;
        end else begin
            if (w_out_free) begin
                // Skid can only hold a beat while the output is also valid,
                // and in that state nothing is accepted, so the two loads
                // below never compete.
                if (r_skid_valid) begin
                    r_out_valid   <= 1'b1;
                    r_out_imm     <= r_skid_imm;
                    r_out_target  <= r_skid_target;
                    r_out_pc      <= r_skid_pc;
                    r_out_fmt     <= r_skid_fmt;
                    r_out_illegal <= r_skid_illegal;
                    r_skid_valid  <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid   <= 1'b1;
                    r_out_imm     <= w_imm;
                    r_out_target  <= w_target;
                    r_out_pc      <= in_pc;
                    r_out_fmt     <= w_fmt;
                    r_out_illegal <= w_illegal;
                end else begin
                    r_out_valid   <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid   <= 1'b1;
                r_skid_imm     <= w_imm;
                r_skid_target  <= w_target;
                r_skid_pc      <= in_pc;
                r_skid_fmt     <= w_fmt;
                r_skid_illegal <= w_illegal;
            end

            if (w_cnt_inc) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_target  = r_out_target;
    assign out_pc      = r_out_pc;
    assign out_fmt     = r_out_fmt;
    assign out_illegal = r_out_illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire
